rf_write_sched: RTL and testbench

- Schedules the single write port of the register file, a 16x16 array of dff-based bit cells, each with one write enable and two read enables.
- Shares that write port between the pipeline writeback stage and a secondary writer with a valid/ready handshake; the secondary writer is a multi-cycle unit or a debug loader.
- Runs a post-reset or on-demand clear sequence that zeroes every register.
- Sits between the WB stage and the register file's write-decoder inputs.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_starve_ctr.sv | 26 ++
 rtl/rf_write_sched.sv | 147 ++++++++++++++
 tb/tb_rf_write_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and enumerations for the register-file write scheduler.
package rf_pkg;

  localparam int NUM_REGS   = 16;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  // Scheduler state: sweeping zeroes through the file, or arbitrating writers.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_sched_state_t;

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CLR  = 2'd1,
    G_WB   = 2'd2,
    G_SEC  = 2'd3
  } rf_grant_t;

endpackage

// File: rtl/rf_starve_ctr.sv
// Saturating count of consecutive cycles the secondary writer was refused.
module rf_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CW-1:0] cnt_reg;

  // Clear has priority over increment; the count parks at LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CW'(LIMIT))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign at_limit = (cnt_reg == CW'(LIMIT));

endmodule

// File: rtl/rf_write_sched.sv
// Arbitrates the register file's single write port between the WB stage,
// a secondary (multi-cycle / debug) writer, and a full-file clear sweep.
module rf_write_sched #(
  parameter int NUM_REGS     = rf_pkg::NUM_REGS,
  parameter int DATA_W       = rf_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_REG     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        wb_stall,
  input  logic                        sec_valid,
  input  logic [$clog2(NUM_REGS)-1:0] sec_addr,
  input  logic [DATA_W-1:0]           sec_data,
  output logic                        sec_ready,
  input  logic                        clr_start,
  output logic                        busy,
  output logic                        rf_wen,
  output logic [$clog2(NUM_REGS)-1:0] rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata
);
  import rf_pkg::*;

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  rf_sched_state_t state_reg, state_next;
  logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
  rf_grant_t       grant;
  logic            starve_at_limit;
  logic            starve_inc, starve_clr;
  logic            wen_next;
  logic [AW-1:0]   waddr_next;
  logic [DATA_W-1:0] wdata_next;

  assign busy = (state_reg == CLEAR);

  // Grant selection: clear sweep owns the port; otherwise a starved secondary
  // writer beats WB, WB beats a fresh secondary request.
  always_comb begin
    grant     = G_NONE;
    sec_ready = 1'b0;
    wb_stall  = 1'b0;
    if (state_reg == CLEAR) begin
      grant    = G_CLR;
      wb_stall = wb_valid;
    end else if (sec_valid && starve_at_limit) begin
      grant     = G_SEC;
      sec_ready = 1'b1;
      wb_stall  = wb_valid;
    end else if (wb_valid) begin
      grant = G_WB;
    end else if (sec_valid) begin
      grant     = G_SEC;
      sec_ready = 1'b1;
    end
  end

  // Route the granted source onto the next write; writes to r0 are dropped
  // when it is hardwired to zero, but the clear sweep still writes it.
  always_comb begin
    waddr_next = rf_waddr;
    wdata_next = rf_wdata;
    wen_next   = 1'b0;
    unique case (grant)
      G_CLR: begin
        waddr_next = clr_cnt_reg;
        wdata_next = '0;
        wen_next   = 1'b1;
      end
      G_WB: begin
        waddr_next = wb_addr;
        wdata_next = wb_data;
        wen_next   = !((ZERO_REG != 0) && (wb_addr == '0));
      end
      G_SEC: begin
        waddr_next = sec_addr;
        wdata_next = sec_data;
        wen_next   = !((ZERO_REG != 0) && (sec_addr == '0));
      end
      default: begin
        wen_next = 1'b0;
      end
    endcase
  end

  // Next state: the sweep walks every address once, then hands over to RUN;
  // a clear request in RUN restarts the sweep from address 0.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == CLEAR) begin
      clr_cnt_next = clr_cnt_reg + 1'b1;
      if (clr_cnt_reg == LAST_ADDR) begin
        state_next   = RUN;
        clr_cnt_next = '0;
      end
    end else if (clr_start) begin
      state_next   = CLEAR;
      clr_cnt_next = '0;
    end
  end

  // State and sweep-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Registered write-port outputs; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen   <= wen_next;
      rf_waddr <= waddr_next;
      rf_wdata <= wdata_next;
    end
  end

  // Starvation only accrues while arbitrating; the sweep and a pending clear
  // both reset it so a fresh RUN phase starts fair.
  assign starve_inc = (state_reg == RUN) && sec_valid && !sec_ready;
  assign starve_clr = (state_reg == CLEAR) || !sec_valid || sec_ready || clr_start;

  rf_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CW    (4)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_at_limit)
  );

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: clear sweeps, WB/secondary arbitration,
// starvation forcing, zero-register suppression, clear request and mid-clear reset.
module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_stall;
  logic        sec_valid;
  logic [3:0]  sec_addr;
  logic [15:0] sec_data;
  logic        sec_ready;
  logic        clr_start;
  logic        busy;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_write_sched #(
    .NUM_REGS     (16),
    .DATA_W       (16),
    .STARVE_LIMIT (4),
    .ZERO_REG     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .sec_valid (sec_valid),
    .sec_addr  (sec_addr),
    .sec_data  (sec_data),
    .sec_ready (sec_ready),
    .clr_start (clr_start),
    .busy      (busy),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  typedef struct {
    logic        wv;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        sv;
    logic [3:0]  sa;
    logic [15:0] sd;
    logic        cs;
    logic        e_stall;
    logic        e_ready;
    logic        e_busy;
    logic        e_wen;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                              input logic sv, input logic [3:0] sa, input logic [15:0] sd,
                              input logic e_stall, input logic e_ready,
                              input logic e_wen, input logic [3:0] e_addr, input logic [15:0] e_data);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.sv = sv; v.sa = sa; v.sd = sd;
    v.cs = 1'b0;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_busy = 1'b0;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                       input logic sv, input logic [3:0] sa, input logic [15:0] sd,
                       input logic cs);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    sec_valid = sv; sec_addr = sa; sec_data = sd;
    clr_start = cs;
  endtask

  // One full clear sweep starting in the first CLEAR cycle. The first cycle's
  // registered outputs are whatever preceded the sweep (fw/fa/fd); afterwards
  // rf_* must trail the sweep address by one cycle. rst_at >= 0 aborts the
  // sweep with a reset asserted in that cycle.
  task automatic clear_sweep(input string tag, input logic fw, input logic fad,
                             input logic [3:0] fa, input logic [15:0] fd, input int rst_at);
    for (int k = 0; k < 16; k++) begin
      drive(k[0], 4'(k), 16'h5A00 + 16'(k), 1'b1, 4'd9, 16'h9999, (k == 5));
      if (k == rst_at) rst = 1'b1;
      @(negedge clk);
      chk($sformatf("%s clr%0d busy", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s clr%0d stall", tag, k), 32'(wb_stall), 32'(wb_valid));
      chk($sformatf("%s clr%0d ready", tag, k), 32'(sec_ready), 32'd0);
      if (k == 0) begin
        chk($sformatf("%s clr0 wen", tag), 32'(rf_wen), 32'(fw));
        if (fad) begin
          chk($sformatf("%s clr0 addr", tag), 32'(rf_waddr), 32'(fa));
          chk($sformatf("%s clr0 data", tag), 32'(rf_wdata), 32'(fd));
        end
      end else begin
        chk($sformatf("%s clr%0d wen", tag, k), 32'(rf_wen), 32'd1);
        chk($sformatf("%s clr%0d addr", tag, k), 32'(rf_waddr), 32'(k - 1));
        chk($sformatf("%s clr%0d data", tag, k), 32'(rf_wdata), 32'd0);
      end
      $display("%s clear cycle %0d: busy=%0b wen=%0b addr=%0d", tag, k, busy, rf_wen, rf_waddr);
      next_cycle();
      if (k == rst_at) begin
        rst = 1'b0;
        return;
      end
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk({tag, " end busy"}, 32'(busy), 32'd0);
    chk({tag, " end wen"}, 32'(rf_wen), 32'd1);
    chk({tag, " end addr"}, 32'(rf_waddr), 32'd15);
    chk({tag, " end data"}, 32'(rf_wdata), 32'd0);
    $display("%s sweep done: busy=%0b last addr=%0d", tag, busy, rf_waddr);
    next_cycle();
    @(negedge clk);
    chk({tag, " idle wen"}, 32'(rf_wen), 32'd0);
    next_cycle();
  endtask

  initial begin
    // Rows are consecutive RUN cycles; expected rf_* reflect the previous row's grant.
    tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 3, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 3, 16'hBEEF);
    tbl[3]  = mk(1, 8, 16'hA000, 1, 5, 16'h1234, 0, 0, 0, 0, 16'h0000);
    tbl[4]  = mk(1, 9, 16'hA001, 1, 5, 16'h1234, 0, 0, 1, 8, 16'hA000);
    tbl[5]  = mk(1, 10, 16'hA002, 1, 5, 16'h1234, 0, 0, 1, 9, 16'hA001);
    tbl[6]  = mk(1, 11, 16'hA003, 1, 5, 16'h1234, 0, 0, 1, 10, 16'hA002);
    tbl[7]  = mk(1, 12, 16'hA004, 1, 5, 16'h1234, 1, 1, 1, 11, 16'hA003);
    tbl[8]  = mk(1, 12, 16'hA004, 0, 0, 16'h0000, 0, 0, 1, 5, 16'h1234);
    tbl[9]  = mk(1, 13, 16'hA005, 0, 0, 16'h0000, 0, 0, 1, 12, 16'hA004);
    tbl[10] = mk(1, 14, 16'hA006, 0, 0, 16'h0000, 0, 0, 1, 13, 16'hA005);
    tbl[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 14, 16'hA006);
    tbl[12] = mk(0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 1, 0, 0, 16'h0000);
    tbl[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[14] = mk(1, 0, 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[16] = mk(1, 2, 16'h2222, 1, 6, 16'h6666, 0, 0, 0, 0, 16'h0000);
    tbl[17] = mk(0, 0, 16'h0000, 1, 6, 16'h6666, 0, 1, 1, 2, 16'h2222);
    tbl[18] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 6, 16'h6666);
    tbl[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

    rst = 1'b1;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Power-up sweep; first cycle checks the reset values of rf_*.
    clear_sweep("reset", 1'b0, 1'b1, 4'd0, 16'd0, -1);

    // Arbitration table.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].cs);
      @(negedge clk);
      chk($sformatf("row%0d stall", i), 32'(wb_stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d ready", i), 32'(sec_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d wen", i), 32'(rf_wen), 32'(tbl[i].e_wen));
      if (tbl[i].e_wen) begin
        chk($sformatf("row%0d addr", i), 32'(rf_waddr), 32'(tbl[i].e_addr));
        chk($sformatf("row%0d data", i), 32'(rf_wdata), 32'(tbl[i].e_data));
      end
      $display("row %0d: stall=%0b ready=%0b wen=%0b addr=%0d data=%h",
               i, wb_stall, sec_ready, rf_wen, rf_waddr, rf_wdata);
      next_cycle();
    end

    // Clear request alongside a WB write to r7: the write still issues first.
    drive(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'd0, 1'b1);
    @(negedge clk);
    chk("clrreq stall", 32'(wb_stall), 32'd0);
    chk("clrreq busy", 32'(busy), 32'd0);
    chk("clrreq wen", 32'(rf_wen), 32'd0);
    $display("clear request with WB r7: stall=%0b busy=%0b", wb_stall, busy);
    next_cycle();
    clear_sweep("clrreq", 1'b1, 1'b1, 4'd7, 16'h7777, -1);

    // Reset while the sweep is issuing address 9, then a full restart.
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1);
    @(negedge clk);
    chk("midrst req busy", 32'(busy), 32'd0);
    $display("clear request before mid-clear reset: busy=%0b", busy);
    next_cycle();
    clear_sweep("midrst_a", 1'b0, 1'b0, 4'd0, 16'd0, 9);
    clear_sweep("midrst_b", 1'b0, 1'b1, 4'd0, 16'd0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
